ram_latency_responder: RTL

//  Responder end of the cpu_ram_if RAM protocol; memory_control is the initiator.

---
 rtl/ram_latency_responder.sv | 132 +++++++++++++
 1 files changed

// File: rtl/ram_latency_responder.sv
// Word-addressed RAM responder for the cpu_ram_if protocol with a fixed BUSY latency.
// Define RAM_STATS_EN to add saturating read/write/error access counters.
module ram_latency_responder #(
  parameter int LAT   = 2,
  parameter int WORDS = 16384,
  parameter int CNT_W = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ramREN,
  input  logic        ramWEN,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [1:0]  ramstate,
  output logic [31:0] ramload
`ifdef RAM_STATS_EN
  ,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count,
  output logic [31:0] err_count
`endif
);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } state_t;

  localparam int              AW       = $clog2(WORDS);
  localparam logic [32:0]     LIMIT    = 33'(WORDS) * 33'd4;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT - 1);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [31:0]       load_n;
  logic [65:0]       req, req_q;
  logic              active, changed, new_req, fault, mem_we;
  logic [AW-1:0]     idx;
  logic [31:0]       mem [WORDS];

  assign req     = {ramREN, ramWEN, ramaddr, ramstore};
  assign active  = ramREN | ramWEN;
  assign changed = (req != req_q);
  assign new_req = active && (changed || state == FREE);
  assign fault   = (ramREN & ramWEN) | (ramaddr[1:0] != 2'b00) | ({1'b0, ramaddr} >= LIMIT);
  assign idx     = ramaddr[AW+1:2];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= FREE;
      cnt     <= '0;
      ramload <= '0;
      req_q   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      ramload <= load_n;
      req_q   <= req;
    end
  end

  // Any fresh or altered request restarts the latency count (or faults), whatever state we are in.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    load_n  = ramload;
    mem_we  = 1'b0;
    if (!active) begin
      state_n = FREE;
    end else if (new_req) begin
      if (fault) begin
        state_n = ERROR;
        load_n  = '0;
      end else begin
        state_n = BUSY;
        cnt_n   = CNT_INIT;
      end
    end else if (state == BUSY) begin
      if (cnt != '0) begin
        cnt_n = cnt - 1'b1;
      end else begin
        state_n = ACCESS;
        if (ramWEN) begin
          mem_we = 1'b1;
          load_n = ramstore;
        end else begin
          load_n = mem[idx];
        end
      end
    end
  end

  always_comb begin
    ramstate = state;
  end

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[idx] <= ramstore;
    end
  end

`ifdef RAM_STATS_EN
  logic rd_evt, wr_evt, err_evt;

  assign rd_evt  = (state == BUSY) && (state_n == ACCESS) && !ramWEN;
  assign wr_evt  = (state == BUSY) && (state_n == ACCESS) && ramWEN;
  assign err_evt = new_req && fault;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rd_count  <= '0;
      wr_count  <= '0;
      err_count <= '0;
    end else begin
      if (rd_evt && rd_count != 32'hFFFF_FFFF) begin
        rd_count <= rd_count + 32'd1;
      end
      if (wr_evt && wr_count != 32'hFFFF_FFFF) begin
        wr_count <= wr_count + 32'd1;
      end
      if (err_evt && err_count != 32'hFFFF_FFFF) begin
        err_count <= err_count + 32'd1;
      end
    end
  end
`endif

endmodule
